tlb_array: RTL

- 16-entry fully associative LoongArch TLB. It is the responder for the TLB interfaces driven by the pipeline.
- Two combinational search ports: s0 for IF fetch translation, s1 for EX/MEM load-store, TLBSRCH and INVTLB operands.
- One combinational read port for TLBRD, one synchronous write port for TLBWR/TLBFILL, and one synchronous INVTLB invalidation port.
- Sits beside the CSR file. The WB stage drives the write, read and invtlb ports.

---
 rtl/tlb_array_pkg.sv | 46 ++++
 rtl/tlb_array_search_port.sv | 69 ++++++
 rtl/tlb_array.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/tlb_array_pkg.sv
// Shared constants, entry layout and the PS-aware VPPN compare for the 16-entry TLB.
package tlb_array_pkg;

    localparam int TLBNUM = 16;
    localparam int IDXW   = 4;

    localparam logic [5:0] PS_4K = 6'd12;
    localparam logic [5:0] PS_4M = 6'd21;

    localparam logic [4:0] INVTLB_ALL0       = 5'd0;
    localparam logic [4:0] INVTLB_ALL1       = 5'd1;
    localparam logic [4:0] INVTLB_G1         = 5'd2;
    localparam logic [4:0] INVTLB_G0         = 5'd3;
    localparam logic [4:0] INVTLB_G0_ASID    = 5'd4;
    localparam logic [4:0] INVTLB_G0_ASID_VA = 5'd5;
    localparam logic [4:0] INVTLB_GA_VA      = 5'd6;

    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } tlb_page_t;

    typedef struct packed {
        logic        e;
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic [9:0]  asid;
        logic        g;
        tlb_page_t   p0;
        tlb_page_t   p1;
    } tlb_entry_t;

    // A 4M page covers an even/odd pair of 2M halves, so only VPPN[18:9] takes part.
    function automatic logic vppn_match(input logic [18:0] ent_vppn,
                                        input logic [5:0]  ent_ps,
                                        input logic [18:0] vppn);
        if (ent_ps == PS_4M) begin
            return ent_vppn[18:9] == vppn[18:9];
        end
        return ent_vppn == vppn;
    endfunction

endpackage

// File: rtl/tlb_array_search_port.sv
// One combinational TLB lookup port; lowest matching index wins on multiple hits.
module tlb_search_port
    import tlb_array_pkg::*;
(
    input  tlb_entry_t [TLBNUM-1:0] entries_i,
    input  logic [18:0]             vppn_i,
    input  logic                    va_bit12_i,
    input  logic [9:0]              asid_i,
    output logic [TLBNUM-1:0]       va_match_o,
    output logic                    found_o,
    output logic [IDXW-1:0]         index_o,
    output logic [19:0]             ppn_o,
    output logic [5:0]              ps_o,
    output logic [1:0]              plv_o,
    output logic [1:0]              mat_o,
    output logic                    d_o,
    output logic                    v_o
);

    logic [TLBNUM-1:0] hit;
    tlb_entry_t        sel;
    tlb_page_t         page;
    logic              odd;

    always_comb begin
        va_match_o = '0;
        hit        = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            va_match_o[i] = vppn_match(entries_i[i].vppn, entries_i[i].ps, vppn_i);
            hit[i] = entries_i[i].e
                   & (entries_i[i].g | (entries_i[i].asid == asid_i))
                   & va_match_o[i];
        end
    end

    // Scanning downwards lets the lowest hitting index overwrite any higher one.
    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (hit[i]) begin
                found_o = 1'b1;
                index_o = IDXW'(i);
            end
        end
    end

    always_comb begin
        sel  = entries_i[index_o];
        odd  = (sel.ps == PS_4M) ? vppn_i[8] : va_bit12_i;
        page = odd ? sel.p1 : sel.p0;
        if (found_o) begin
            ppn_o = page.ppn;
            ps_o  = sel.ps;
            plv_o = page.plv;
            mat_o = page.mat;
            d_o   = page.d;
            v_o   = page.v;
        end else begin
            ppn_o = '0;
            ps_o  = '0;
            plv_o = '0;
            mat_o = '0;
            d_o   = 1'b0;
            v_o   = 1'b0;
        end
    end

endmodule

// File: rtl/tlb_array.sv
// 16-entry fully associative LoongArch TLB: two search ports, TLBRD read, TLBWR/TLBFILL write, INVTLB.
module tlb_array
    import tlb_array_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [18:0]     s0_vppn,
    input  logic            s0_va_bit12,
    input  logic [9:0]      s0_asid,
    output logic            s0_found,
    output logic [IDXW-1:0] s0_index,
    output logic [19:0]     s0_ppn,
    output logic [5:0]      s0_ps,
    output logic [1:0]      s0_plv,
    output logic [1:0]      s0_mat,
    output logic            s0_d,
    output logic            s0_v,
    input  logic [18:0]     s1_vppn,
    input  logic            s1_va_bit12,
    input  logic [9:0]      s1_asid,
    output logic            s1_found,
    output logic [IDXW-1:0] s1_index,
    output logic [19:0]     s1_ppn,
    output logic [5:0]      s1_ps,
    output logic [1:0]      s1_plv,
    output logic [1:0]      s1_mat,
    output logic            s1_d,
    output logic            s1_v,
    input  logic            invtlb_valid,
    input  logic [4:0]      invtlb_op,
    input  logic            we,
    input  logic [IDXW-1:0] w_index,
    input  logic            w_e,
    input  logic [18:0]     w_vppn,
    input  logic [5:0]      w_ps,
    input  logic [9:0]      w_asid,
    input  logic            w_g,
    input  logic [19:0]     w_ppn0,
    input  logic [1:0]      w_plv0,
    input  logic [1:0]      w_mat0,
    input  logic            w_d0,
    input  logic            w_v0,
    input  logic [19:0]     w_ppn1,
    input  logic [1:0]      w_plv1,
    input  logic [1:0]      w_mat1,
    input  logic            w_d1,
    input  logic            w_v1,
    input  logic [IDXW-1:0] r_index,
    output logic            r_e,
    output logic [18:0]     r_vppn,
    output logic [5:0]      r_ps,
    output logic [9:0]      r_asid,
    output logic            r_g,
    output logic [19:0]     r_ppn0,
    output logic [1:0]      r_plv0,
    output logic [1:0]      r_mat0,
    output logic            r_d0,
    output logic            r_v0,
    output logic [19:0]     r_ppn1,
    output logic [1:0]      r_plv1,
    output logic [1:0]      r_mat1,
    output logic            r_d1,
    output logic            r_v1
);

    tlb_entry_t [TLBNUM-1:0] entries_q, entries_d;
    tlb_entry_t              w_entry, rd;
    logic [TLBNUM-1:0]       s1_va_match, s0_va_match_unused;
    logic [TLBNUM-1:0]       inv_hit;

    tlb_search_port u_s0 (
        .entries_i  (entries_q),
        .vppn_i     (s0_vppn),
        .va_bit12_i (s0_va_bit12),
        .asid_i     (s0_asid),
        .va_match_o (s0_va_match_unused),
        .found_o    (s0_found),
        .index_o    (s0_index),
        .ppn_o      (s0_ppn),
        .ps_o       (s0_ps),
        .plv_o      (s0_plv),
        .mat_o      (s0_mat),
        .d_o        (s0_d),
        .v_o        (s0_v)
    );

    // s1 carries the INVTLB operands, so its VA match vector doubles as the op 5/6 compare.
    tlb_search_port u_s1 (
        .entries_i  (entries_q),
        .vppn_i     (s1_vppn),
        .va_bit12_i (s1_va_bit12),
        .asid_i     (s1_asid),
        .va_match_o (s1_va_match),
        .found_o    (s1_found),
        .index_o    (s1_index),
        .ppn_o      (s1_ppn),
        .ps_o       (s1_ps),
        .plv_o      (s1_plv),
        .mat_o      (s1_mat),
        .d_o        (s1_d),
        .v_o        (s1_v)
    );

    always_comb begin
        inv_hit = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            case (invtlb_op)
                INVTLB_ALL0, INVTLB_ALL1: inv_hit[i] = 1'b1;
                INVTLB_G1:         inv_hit[i] = entries_q[i].g;
                INVTLB_G0:         inv_hit[i] = ~entries_q[i].g;
                INVTLB_G0_ASID:    inv_hit[i] = ~entries_q[i].g & (entries_q[i].asid == s1_asid);
                INVTLB_G0_ASID_VA: inv_hit[i] = ~entries_q[i].g & (entries_q[i].asid == s1_asid)
                                              & s1_va_match[i];
                INVTLB_GA_VA:      inv_hit[i] = (entries_q[i].g | (entries_q[i].asid == s1_asid))
                                              & s1_va_match[i];
                default:           inv_hit[i] = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_entry.e      = w_e;
        w_entry.vppn   = w_vppn;
        w_entry.ps     = w_ps;
        w_entry.asid   = w_asid;
        w_entry.g      = w_g;
        w_entry.p0.ppn = w_ppn0;
        w_entry.p0.plv = w_plv0;
        w_entry.p0.mat = w_mat0;
        w_entry.p0.d   = w_d0;
        w_entry.p0.v   = w_v0;
        w_entry.p1.ppn = w_ppn1;
        w_entry.p1.plv = w_plv1;
        w_entry.p1.mat = w_mat1;
        w_entry.p1.d   = w_d1;
        w_entry.p1.v   = w_v1;
    end

    // Invalidate first, then write, so a same-cycle write always lands intact.
    always_comb begin
        entries_d = entries_q;
        if (invtlb_valid) begin
            for (int i = 0; i < TLBNUM; i++) begin
                if (inv_hit[i]) begin
                    entries_d[i].e = 1'b0;
                end
            end
        end
        if (we) begin
            entries_d[w_index] = w_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            entries_q <= '0;
        end else begin
            entries_q <= entries_d;
        end
    end

    assign rd     = entries_q[r_index];
    assign r_e    = rd.e;
    assign r_vppn = rd.vppn;
    assign r_ps   = rd.ps;
    assign r_asid = rd.asid;
    assign r_g    = rd.g;
    assign r_ppn0 = rd.p0.ppn;
    assign r_plv0 = rd.p0.plv;
    assign r_mat0 = rd.p0.mat;
    assign r_d0   = rd.p0.d;
    assign r_v0   = rd.p0.v;
    assign r_ppn1 = rd.p1.ppn;
    assign r_plv1 = rd.p1.plv;
    assign r_mat1 = rd.p1.mat;
    assign r_d1   = rd.p1.d;
    assign r_v1   = rd.p1.v;

endmodule
